// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU with PC/branch address adders, all outputs registered.
// ALU control is decoded from alu_op/funct3, and the result plus next-PC select are
// loaded on every edge where in_valid is high.
// Optional feature: define ALU_FUNCT7_EN to add the funct7_5 input, which makes
// SUB (funct3 000, R-type only) and SRA (funct3 101) reachable through funct3.
module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      funct3,
`ifdef ALU_FUNCT7_EN
    input  logic            funct7_5,
`endif
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            branch,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    logic [3:0]      ctrl_d;
    logic [XLEN-1:0] result_d;
    logic            zero_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic [XLEN-1:0] branch_target_d;
    logic [XLEN-1:0] next_pc_d;
    logic [SHW-1:0]  shamt;
    logic            sub_sel;
    logic            sra_sel;

    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [3:0]      alu_ctrl_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [XLEN-1:0] branch_target_q;
    logic [XLEN-1:0] next_pc_q;

    assign shamt = op_b[SHW-1:0];

    // Only the R-type class (alu_op 010) may turn funct3 000 into SUB; ADDI has no SUB form.
`ifdef ALU_FUNCT7_EN
    assign sub_sel = funct7_5 && (alu_op == 3'b010);
    assign sra_sel = funct7_5;
`else
    assign sub_sel = 1'b0;
    assign sra_sel = 1'b0;
`endif

    // Decode operation class and funct3 into the 4-bit ALU control code.
    always_comb begin
        ctrl_d = ALU_ADD;
        case (alu_op)
            3'b000: ctrl_d = ALU_ADD;
            3'b001: ctrl_d = ALU_SUB;
            3'b010, 3'b011: begin
                case (funct3)
                    3'b000:  ctrl_d = sub_sel ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl_d = ALU_SLL;
                    3'b010:  ctrl_d = ALU_SLT;
                    3'b011:  ctrl_d = ALU_SLTU;
                    3'b100:  ctrl_d = ALU_XOR;
                    3'b101:  ctrl_d = sra_sel ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl_d = ALU_OR;
                    default: ctrl_d = ALU_AND;
                endcase
            end
            default: ctrl_d = ALU_ADD;
        endcase
    end

    // Compute the ALU result for the decoded control code; unused codes give 0.
    always_comb begin
        result_d = '0;
        case (ctrl_d)
            ALU_AND:  result_d = op_a & op_b;
            ALU_OR:   result_d = op_a | op_b;
            ALU_ADD:  result_d = op_a + op_b;
            ALU_XOR:  result_d = op_a ^ op_b;
            ALU_SLL:  result_d = op_a << shamt;
            ALU_SRL:  result_d = op_a >> shamt;
            ALU_SUB:  result_d = op_a - op_b;
            ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_SRA:  result_d = $unsigned($signed(op_a) >>> shamt);
            default:  result_d = '0;
        endcase
    end

    // Address adders and branch resolution using this cycle's zero flag.
    always_comb begin
        zero_d          = (result_d == '0);
        pc_plus4_d      = pc + XLEN'(PC_INC);
        branch_target_d = pc + imm;
        next_pc_d       = (branch && zero_d) ? branch_target_d : pc_plus4_d;
    end

    // Output registers: load on in_valid, otherwise hold data and drop out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q     <= 1'b0;
            result_q        <= '0;
            zero_q          <= 1'b0;
            alu_ctrl_q      <= '0;
            pc_plus4_q      <= '0;
            branch_target_q <= '0;
            next_pc_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q        <= result_d;
                zero_q          <= zero_d;
                alu_ctrl_q      <= ctrl_d;
                pc_plus4_q      <= pc_plus4_d;
                branch_target_q <= branch_target_d;
                next_pc_q       <= next_pc_d;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign pc_plus4      = pc_plus4_q;
    assign branch_target = branch_target_q;
    assign next_pc       = next_pc_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=32, PC_INC=4): directed vector table,
// reset/hold sequences, then randomized traffic against a behavioural model.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [2:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        branch;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_ctrl;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    int n_cmp = 0;
    int n_err = 0;

    // Expected registered state
    logic        e_valid;
    logic [31:0] e_result;
    logic        e_zero;
    logic [3:0]  e_ctrl;
    logic [31:0] e_p4;
    logic [31:0] e_bt;
    logic [31:0] e_npc;

    alu_exec_unit #(.XLEN(32), .PC_INC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .alu_op       (alu_op),
        .funct3       (funct3),
`ifdef ALU_FUNCT7_EN
        .funct7_5     (funct7_5),
`endif
        .op_a         (op_a),
        .op_b         (op_b),
        .pc           (pc),
        .imm          (imm),
        .branch       (branch),
        .out_valid    (out_valid),
        .result       (result),
        .zero         (zero),
        .alu_ctrl     (alu_ctrl),
        .pc_plus4     (pc_plus4),
        .branch_target(branch_target),
        .next_pc      (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
        chk({tag, ".result"}, 64'(result), 64'(e_result));
        chk({tag, ".zero"}, 64'(zero), 64'(e_zero));
        chk({tag, ".alu_ctrl"}, 64'(alu_ctrl), 64'(e_ctrl));
        chk({tag, ".pc_plus4"}, 64'(pc_plus4), 64'(e_p4));
        chk({tag, ".branch_target"}, 64'(branch_target), 64'(e_bt));
        chk({tag, ".next_pc"}, 64'(next_pc), 64'(e_npc));
    endtask

    task automatic clear_model();
        e_valid = 0; e_result = 0; e_zero = 0; e_ctrl = 0; e_p4 = 0; e_bt = 0; e_npc = 0;
    endtask

    // Behavioural reference: pick the operation by name from the spec tables,
    // then evaluate it with plain arithmetic.
    function automatic void model(input logic [2:0] aop, input logic [2:0] f3,
                                  input logic f7, input logic [31:0] a,
                                  input logic [31:0] b, output logic [3:0] ctrl,
                                  output logic [31:0] res);
        string opn;
        int    sh;
        logic [63:0] sext;
        sh = int'(b % 32);
        if (aop == 3'd1) opn = "SUB";
        else if (aop == 3'd2 || aop == 3'd3) begin
            case (f3)
                3'd0: opn = "ADD";
                3'd1: opn = "SLL";
                3'd2: opn = "SLT";
                3'd3: opn = "SLTU";
                3'd4: opn = "XOR";
                3'd5: opn = "SRL";
                3'd6: opn = "OR";
                default: opn = "AND";
            endcase
`ifdef ALU_FUNCT7_EN
            if (f7 && f3 == 3'd0 && aop == 3'd2) opn = "SUB";
            if (f7 && f3 == 3'd5) opn = "SRA";
`endif
        end else opn = "ADD";
        if (f7 === 1'bx) opn = "ADD"; // unreachable; keeps f7 used in default build
        sext = {{32{a[31]}}, a};
        case (opn)
            "AND":  begin ctrl = 4'd0; res = a & b; end
            "OR":   begin ctrl = 4'd1; res = a | b; end
            "ADD":  begin ctrl = 4'd2; res = 32'(64'(a) + 64'(b)); end
            "XOR":  begin ctrl = 4'd3; res = a ^ b; end
            "SLL":  begin ctrl = 4'd4; res = 32'(64'(a) * (64'd1 << sh)); end
            "SRL":  begin ctrl = 4'd5; res = a / (32'd1 << sh); end
            "SUB":  begin ctrl = 4'd6; res = 32'(64'(a) + 64'(~b) + 64'd1); end
            "SLT":  begin ctrl = 4'd7; res = (int'(a) < int'(b)) ? 32 'd1 : 32'd0; end
            "SLTU": begin ctrl = 4'd8; res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0; end
            default: begin ctrl = 4'd9; res = sext[sh +: 32]; end
        endcase
    endfunction

    // Update expected state from the currently driven inputs (called after an edge).
    task automatic model_edge();
        logic [3:0]  c;
        logic [31:0] r;
        e_valid = in_valid;
        if (in_valid) begin
            model(alu_op, funct3, funct7_5, op_a, op_b, c, r);
            e_ctrl   = c;
            e_result = r;
            e_zero   = (r == 0);
            e_p4     = pc + 32'd4;
            e_bt     = pc + imm;
            e_npc    = (branch && e_zero) ? e_bt : e_p4;
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] aop, input logic [2:0] f3,
                         input logic f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic br);
        in_valid = v; alu_op = aop; funct3 = f3; funct7_5 = f7;
        op_a = a; op_b = b; pc = p; imm = im; branch = br;
    endtask

    typedef struct {
        logic [2:0]  aop;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [31:0] im;
        logic        br;
        logic [31:0] x_res;
        logic        x_zero;
        logic [3:0]  x_ctrl;
        logic [31:0] x_npc;
    } vec_t;

    vec_t vt[$];

    initial begin
        vt.push_back('{3'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b0,
                       32'h0, 1'b1, 4'b0010, 32'h4});
        vt.push_back('{3'd1, 3'd0, 32'd7, 32'd7, 32'h100, 32'h20, 1'b1,
                       32'h0, 1'b1, 4'b0110, 32'h120});
        vt.push_back('{3'd1, 3'd0, 32'd8, 32'd7, 32'h100, 32'h20, 1'b1,
                       32'h1, 1'b0, 4'b0110, 32'h104});
        vt.push_back('{3'd2, 3'd0, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h8000_0001, 1'b0, 4'b0010, 32'h204});
        vt.push_back('{3'd2, 3'd1, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h0, 1'b1, 4'b0100, 32'h204});
        vt.push_back('{3'd2, 3'd2, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h1, 1'b0, 4'b0111, 32'h204});
        vt.push_back('{3'd2, 3'd3, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h0, 1'b1, 4'b1000, 32'h204});
        vt.push_back('{3'd2, 3'd4, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h8000_0001, 1'b0, 4'b0011, 32'h204});
        vt.push_back('{3'd2, 3'd5, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h4000_0000, 1'b0, 4'b0101, 32'h204});
        vt.push_back('{3'd2, 3'd6, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h8000_0001, 1'b0, 4'b0001, 32'h204});
        vt.push_back('{3'd2, 3'd7, 32'h8000_0000, 32'd1, 32'h200, 32'h0, 1'b0,
                       32'h0, 1'b1, 4'b0000, 32'h204});
        vt.push_back('{3'd5, 3'd1, 32'd5, 32'd3, 32'h10, 32'h0, 1'b0,
                       32'h8, 1'b0, 4'b0010, 32'h14});
        vt.push_back('{3'd3, 3'd5, 32'h8000_0000, 32'd4, 32'h10, 32'h0, 1'b0,
                       32'h0800_0000, 1'b0, 4'b0101, 32'h14});
        vt.push_back('{3'd2, 3'd7, 32'hF0, 32'h0F, 32'h300, 32'hFFFF_FFF0, 1'b1,
                       32'h0, 1'b1, 4'b0000, 32'h2F0});
        vt.push_back('{3'd2, 3'd1, 32'd1, 32'h21, 32'h0, 32'h0, 1'b1,
                       32'h2, 1'b0, 4'b0100, 32'h4});
        vt.push_back('{3'd2, 3'd2, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'h8, 1'b1,
                       32'h1, 1'b0, 4'b0111, 32'h4});
    end

    initial begin
        clear_model();
        reset = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        #2 reset = 1'b0;
        #1 chk_all("reset_init");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        chk_all("reset_hold");

        // Directed table
        foreach (vt[i]) begin
            drive(1'b1, vt[i].aop, vt[i].f3, 1'b0, vt[i].a, vt[i].b, vt[i].p, vt[i].im,
                  vt[i].br);
            @(posedge clk); #1;
            model_edge();
            chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d.result", i), 64'(result), 64'(vt[i].x_res));
            chk($sformatf("vec%0d.zero", i), 64'(zero), 64'(vt[i].x_zero));
            chk($sformatf("vec%0d.alu_ctrl", i), 64'(alu_ctrl), 64'(vt[i].x_ctrl));
            chk($sformatf("vec%0d.next_pc", i), 64'(next_pc), 64'(vt[i].x_npc));
            chk($sformatf("vec%0d.pc_plus4", i), 64'(pc_plus4), 64'(vt[i].p + 32'd4));
        end

        // Shift-right with funct7_5 set, then a hold cycle
        drive(1'b1, 3'd2, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'h40, 32'h8, 1'b0);
        @(posedge clk); #1;
`ifdef ALU_FUNCT7_EN
        chk("sra.result", 64'(result), 64'hF800_0000);
        chk("sra.alu_ctrl", 64'(alu_ctrl), 64'd9);
`else
        chk("srl_f7.result", 64'(result), 64'h0800_0000);
        chk("srl_f7.alu_ctrl", 64'(alu_ctrl), 64'd5);
`endif
        model_edge();
        drive(1'b0, 3'd1, 3'd0, 1'b0, 32'h1234, 32'h1, 32'h999, 32'h4, 1'b1);
        @(posedge clk); #1;
        model_edge();
        chk("hold.out_valid", 64'(out_valid), 64'd0);
`ifdef ALU_FUNCT7_EN
        chk("hold.result", 64'(result), 64'hF800_0000);
`else
        chk("hold.result", 64'(result), 64'h0800_0000);
`endif
        chk_all("hold");

        // Mid-run asynchronous reset with a valid op on the inputs
        drive(1'b1, 3'd0, 3'd0, 1'b0, 32'd3, 32'd4, 32'h500, 32'h10, 1'b0);
        @(posedge clk); #1;
        model_edge();
        chk_all("pre_rst");
        #2 reset = 1'b0;
        #1 clear_model();
        chk_all("mid_rst_async");
        @(posedge clk); #1;
        chk_all("mid_rst_edge");
        reset = 1'b1;
        @(posedge clk); #1;
        model_edge();
        chk("post_rst.out_valid", 64'(out_valid), 64'd1);
        chk("post_rst.result", 64'(result), 64'd7);
        chk_all("post_rst");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom_range(0, 40);
                default: b = $urandom();
            endcase
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b, $urandom(),
                  $urandom(), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            model_edge();
            chk_all($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
